// File: rtl/shift_register_sipo_framed_if.sv
// rtl/shift_register_sipo_framed_if.sv - completed-word valid/ready handshake between deserialiser and consumer
interface shift_register_sipo_framed_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] po;
    logic             po_vld;
    logic             po_rdy;

    modport master (
        output po,
        output po_vld,
        input  po_rdy
    );

    modport slave (
        input  po,
        input  po_vld,
        output po_rdy
    );
endinterface

// File: rtl/shift_register_sipo_framed.sv
// rtl/shift_register_sipo_framed.sv - framed serial-in/parallel-out deserialiser with held word output
module shift_register_sipo_framed #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                       c,
    input  logic                       r,
    input  logic                       ce,
    input  logic                       si,
    input  logic                       sync,
    shift_register_sipo_framed_if.master wo,
    output logic [WIDTH-1:0]           sr,
    output logic [$clog2(WIDTH)-1:0]   cnt,
    output logic                       ovf,
    output logic                       ovf_stk
);
    localparam int            CW      = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt_next;
    logic             complete;
    logic             accept;

    always_comb begin
        sr_next  = LSB_FIRST ? {si, sr[WIDTH-1:1]} : {sr[WIDTH-2:0], si};
        cnt_next = cnt;
        if (sync) begin
            // A sync edge with a bit present makes that bit the first of the new frame.
            cnt_next = ce ? CNT_ONE : '0;
        end else if (ce) begin
            cnt_next = (cnt == CNT_MAX) ? '0 : cnt + CNT_ONE;
        end
        complete = ce && !sync && (cnt == CNT_MAX);
        accept   = !wo.po_vld || wo.po_rdy;
    end

    always_ff @(posedge c) begin
        if (r) begin
            sr        <= '0;
            cnt       <= '0;
            wo.po     <= '0;
            wo.po_vld <= 1'b0;
            ovf       <= 1'b0;
            ovf_stk   <= 1'b0;
        end else begin
            ovf <= 1'b0;
            cnt <= cnt_next;
            if (ce) begin
                sr <= sr_next;
            end
            if (complete) begin
                if (accept) begin
                    wo.po     <= sr_next;
                    wo.po_vld <= 1'b1;
                end else begin
                    // Holding register still owned by the consumer: drop the new word.
                    ovf     <= 1'b1;
                    ovf_stk <= 1'b1;
                end
            end else if (wo.po_vld && wo.po_rdy) begin
                wo.po_vld <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_shift_register_sipo_framed.sv
// tb/tb_shift_register_sipo_framed.sv - directed scoreboard bench for both bit orders of the framed deserialiser
module tb_shift_register_sipo_framed;
    localparam int W  = 8;
    localparam int CW = 3;

    logic c = 1'b0;
    logic r, ce, si, sync;
    always #5 c = ~c;

    shift_register_sipo_framed_if #(.WIDTH(W)) if0 ();
    shift_register_sipo_framed_if #(.WIDTH(W)) if1 ();

    logic [W-1:0]  sr0, sr1;
    logic [CW-1:0] cnt0, cnt1;
    logic          ovf0, ovf1, stk0, stk1;

    shift_register_sipo_framed #(.WIDTH(W), .LSB_FIRST(1'b0)) dut0 (
        .c(c), .r(r), .ce(ce), .si(si), .sync(sync), .wo(if0),
        .sr(sr0), .cnt(cnt0), .ovf(ovf0), .ovf_stk(stk0)
    );
    shift_register_sipo_framed #(.WIDTH(W), .LSB_FIRST(1'b1)) dut1 (
        .c(c), .r(r), .ce(ce), .si(si), .sync(sync), .wo(if1),
        .sr(sr1), .cnt(cnt1), .ovf(ovf1), .ovf_stk(stk1)
    );

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] q0[$];
    logic [W-1:0] q1[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge c);
        @(negedge c);
    endtask

    task automatic set_rdy(input logic v);
        if0.po_rdy = v;
        if1.po_rdy = v;
    endtask

    task automatic shift(input logic b, input logic s);
        ce = 1'b1; si = b; sync = s;
        tick();
        ce = 1'b0; sync = 1'b0;
    endtask

    // Bits go out in time order w[W-1] first; rdy_last drives po_rdy on the final edge only.
    task automatic send_word(input logic [W-1:0] w, input logic rdy_body, input logic rdy_last);
        set_rdy(rdy_body);
        for (int i = W - 1; i >= 0; i--) begin
            if (i == 0) set_rdy(rdy_last);
            shift(w[i], 1'b0);
        end
    endtask

    task automatic expect_word(input string tag);
        logic [W-1:0] e0, e1;
        e0 = q0.pop_front();
        e1 = q1.pop_front();
        chk({tag, "_po0"}, 32'(if0.po), 32'(e0));
        chk({tag, "_po1"}, 32'(if1.po), 32'(e1));
        chk({tag, "_vld0"}, 32'(if0.po_vld), 32'd1);
        chk({tag, "_vld1"}, 32'(if1.po_vld), 32'd1);
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] o;
        for (int i = 0; i < W; i++) o[i] = v[W-1-i];
        return o;
    endfunction

    initial begin
        r = 1'b1; ce = 1'b0; si = 1'b0; sync = 1'b0;
        set_rdy(1'b0);
        tick(); tick();
        r = 1'b0;

        // mid-frame reset with a word pending
        send_word(8'h77, 1'b0, 1'b0);
        shift(1'b1, 1'b0); shift(1'b0, 1'b0); shift(1'b1, 1'b0);
        chk("pre_rst_cnt", 32'(cnt0), 32'd3);
        chk("pre_rst_vld", 32'(if0.po_vld), 32'd1);
        r = 1'b1; set_rdy(1'b1); ce = 1'b1; sync = 1'b1;
        tick(); tick();
        r = 1'b0; set_rdy(1'b0); ce = 1'b0; sync = 1'b0;
        chk("rst_sr", 32'(sr0), 32'd0);
        chk("rst_po", 32'(if0.po), 32'd0);
        chk("rst_cnt", 32'(cnt0), 32'd0);
        chk("rst_vld", 32'(if0.po_vld), 32'd0);
        chk("rst_ovf", 32'(ovf0), 32'd0);
        chk("rst_stk", 32'(stk0), 32'd0);
        chk("rst_sr1", 32'(sr1), 32'd0);
        chk("rst_vld1", 32'(if1.po_vld), 32'd0);

        // 0xA5 is a bit palindrome, so both orders agree
        q0.push_back(8'hA5); q1.push_back(8'hA5);
        send_word(8'hA5, 1'b1, 1'b1);
        expect_word("a5");
        chk("a5_cnt", 32'(cnt0), 32'd0);
        tick();
        chk("a5_vld_fall", 32'(if0.po_vld), 32'd0);
        chk("a5_po_hold", 32'(if0.po), 32'hA5);

        q0.push_back(8'hC0); q1.push_back(8'h03);
        send_word(8'hC0, 1'b1, 1'b1);
        expect_word("c0");
        tick();

        // overflow: second word dropped while the first is unconsumed
        q0.push_back(8'h3C); q1.push_back(rev(8'h3C));
        send_word(8'h3C, 1'b0, 1'b0);
        expect_word("ov_first");
        chk("ov_no_early", 32'(ovf0), 32'd0);
        send_word(8'h81, 1'b0, 1'b0);
        chk("ov_pulse0", 32'(ovf0), 32'd1);
        chk("ov_pulse1", 32'(ovf1), 32'd1);
        chk("ov_po_kept", 32'(if0.po), 32'h3C);
        chk("ov_stk", 32'(stk0), 32'd1);
        chk("ov_cnt", 32'(cnt0), 32'd0);
        set_rdy(1'b1);
        tick();
        chk("ov_pulse_end", 32'(ovf0), 32'd0);
        chk("ov_vld_fall", 32'(if0.po_vld), 32'd0);
        chk("ov_stk_held", 32'(stk0), 32'd1);

        // transfer and completion on the same edge
        q0.push_back(8'h12); q1.push_back(rev(8'h12));
        send_word(8'h12, 1'b0, 1'b0);
        expect_word("b2b_w1");
        q0.push_back(8'h6B); q1.push_back(8'hD6);
        send_word(8'h6B, 1'b0, 1'b1);
        expect_word("b2b_w2");
        chk("b2b_no_ovf", 32'(ovf0), 32'd0);
        set_rdy(1'b1);
        tick();
        chk("b2b_drain", 32'(if0.po_vld), 32'd0);

        // sync with a bit restarts the frame; stale bits never reach po
        shift(1'b1, 1'b0); shift(1'b0, 1'b0); shift(1'b1, 1'b0);
        shift(1'b1, 1'b0); shift(1'b0, 1'b0);
        chk("sy_cnt5", 32'(cnt0), 32'd5);
        shift(1'b1, 1'b1);
        chk("sy_cnt1", 32'(cnt0), 32'd1);
        chk("sy_vld", 32'(if0.po_vld), 32'd0);
        q0.push_back(8'hB2); q1.push_back(8'h4D);
        shift(1'b0, 1'b0); shift(1'b1, 1'b1 & 1'b0); shift(1'b1, 1'b0);
        shift(1'b0, 1'b0); shift(1'b0, 1'b0); shift(1'b1, 1'b0);
        shift(1'b0, 1'b0);
        expect_word("sy_word");
        chk("sy_word_cnt", 32'(cnt0), 32'd0);

        // sync without a bit clears the count only
        shift(1'b1, 1'b0); shift(1'b1, 1'b0); shift(1'b1, 1'b0);
        chk("sy0_sr_pre", 32'(sr0), 32'h97);
        chk("sy0_sr1_pre", 32'(sr1), 32'hE9);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("sy0_cnt", 32'(cnt0), 32'd0);
        chk("sy0_sr", 32'(sr0), 32'h97);
        chk("sy0_sr1", 32'(sr1), 32'hE9);
        chk("sy0_po", 32'(if0.po), 32'hB2);
        q0.push_back(8'h5A); q1.push_back(8'h5A);
        send_word(8'h5A, 1'b1, 1'b1);
        expect_word("sy0_next");
        chk("q_empty", 32'(q0.size() + q1.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
